// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Provides the write-port address width, the XZR index and the requester source encoding.
package regfile_arb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WB_DATA_W  = 64;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic {
        SRC_EXEC = 1'b0,
        SRC_LOAD = 1'b1
    } wb_src_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

    // The starvation counter must be able to hold STARVE_LIMIT and is never narrower than 2 bits.
    function automatic int unsigned starve_cnt_w(input int unsigned limit);
        return ($clog2(limit + 1) < 2) ? 2 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester handshakes plus the registered register-file write port.
// master = requester/register-file side, slave = arbiter.
interface regfile_wb_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int unsigned N = WB_DATA_W
);
    logic                  req0_valid;
    logic [REG_ADDR_W-1:0] req0_addr;
    logic [N-1:0]          req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [REG_ADDR_W-1:0] req1_addr;
    logic [N-1:0]          req1_data;
    logic                  req1_ready;
    logic                  we3;
    logic [REG_ADDR_W-1:0] wa3;
    logic [N-1:0]          wd3;
    wb_src_t               grant_id;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  we3, wa3, wd3, grant_id
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output we3, wa3, wd3, grant_id
    );
endinterface

// File: rtl/regfile_wb_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the execute requester waited while valid.
// hit_o flags that the limit is reached and req0 must win the next tie.
module arb_starve_counter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic hit_o
);
    localparam int unsigned W = starve_cnt_w(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign hit_o = (cnt_q == W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !hit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between execute (req0) and load (req1) writeback.
// Load has fixed priority; a starvation guard hands the tie to execute after STARVE_LIMIT waits.
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned N = WB_DATA_W,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter logic [REG_ADDR_W-1:0] ZERO_REG = regfile_arb_pkg::ZERO_REG
) (
    input  logic clk,
    input  logic reset,
    regfile_wb_arbiter_if.slave bus
);
    logic gnt0;
    logic gnt1;
    logic starve_hit;
    wb_req_t sel;

    logic                  we3_q, we3_d;
    logic [REG_ADDR_W-1:0] wa3_q, wa3_d;
    logic [N-1:0]          wd3_q, wd3_d;
    wb_src_t               gid_q, gid_d;

    // Grants already include the valid, so a grant is a completed handshake at the next edge.
    assign gnt1 = !reset && bus.req1_valid && !(bus.req0_valid && starve_hit);
    assign gnt0 = !reset && bus.req0_valid && !gnt1;

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc_i (bus.req0_valid && !gnt0),
        .clr_i (!bus.req0_valid || gnt0),
        .hit_o (starve_hit)
    );

    always_comb begin
        sel   = gnt1 ? '{addr: bus.req1_addr, data: bus.req1_data}
                     : '{addr: bus.req0_addr, data: bus.req0_data};
        we3_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        gid_d = gid_q;
        if (gnt0 || gnt1) begin
            // XZR writes still retire the request but never reach the register file.
            we3_d = (sel.addr != ZERO_REG);
            wa3_d = sel.addr;
            wd3_d = sel.data;
            gid_d = gnt1 ? SRC_LOAD : SRC_EXEC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
            gid_q <= SRC_EXEC;
        end else begin
            we3_q <= we3_d;
            wa3_q <= wa3_d;
            wd3_q <= wd3_d;
            gid_q <= gid_d;
        end
    end

    assign bus.we3      = we3_q;
    assign bus.wa3      = wa3_q;
    assign bus.wd3      = wd3_q;
    assign bus.grant_id = gid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios then randomized traffic,
// checked against a rule-level arbitration model and a shadow register file.
module tb_regfile_wb_arbiter;
    import regfile_arb_pkg::*;

    localparam int LIMIT = 3;

    logic clk;
    logic reset;

    regfile_wb_arbiter_if #(.N(64)) bus ();

    regfile_wb_arbiter #(
        .N            (64),
        .STARVE_LIMIT (LIMIT),
        .ZERO_REG     (5'd31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        gid;
    } exp_t;

    exp_t        exp_q[$];
    int          ncmp;
    int          nfail;
    int          starve;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;
    logic        m_gid;
    logic [63:0] model_rf[32];
    logic [63:0] tb_rf[32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, check readys, predict the registered write.
    task automatic cycle(input bit r,
                         input bit v0, input logic [4:0] a0, input logic [63:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [63:0] d1,
                         output bit g0, output bit g1);
        exp_t e;
        @(negedge clk);
        reset          = r;
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!r) begin
            if (v1 && !(v0 && starve == LIMIT)) g1 = 1'b1;
            else if (v0) g0 = 1'b1;
        end
        #1;
        chk("req0_ready", 64'(bus.req0_ready), 64'(g0));
        chk("req1_ready", 64'(bus.req1_ready), 64'(g1));
        if (r) begin
            starve = 0;
            m_wa = '0; m_wd = '0; m_gid = 1'b0;
            e.we = 1'b0;
        end else begin
            e.we = 1'b0;
            if (g0 || g1) begin
                m_wa  = g1 ? a1 : a0;
                m_wd  = g1 ? d1 : d0;
                m_gid = g1;
                e.we  = (m_wa != 5'd31);
                if (e.we) model_rf[m_wa] = m_wd;
            end
            if (v0 && !g0) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
            else starve = 0;
        end
        e.wa = m_wa; e.wd = m_wd; e.gid = m_gid;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        bit g0, g1;
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, g0, g1);
    endtask

    // Monitor: every edge the write port presents a result that the scoreboard predicted.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("we3", 64'(bus.we3), 64'(e.we));
                chk("wa3", 64'(bus.wa3), 64'(e.wa));
                chk("wd3", bus.wd3, e.wd);
                chk("grant_id", 64'(bus.grant_id), 64'(e.gid));
                if (bus.we3 && bus.wa3 != 5'd31) tb_rf[bus.wa3] = bus.wd3;
            end
        end
    end

    initial begin
        bit g0, g1;
        bit p0, p1, r;
        logic [4:0]  a0, a1;
        logic [63:0] d0, d1;
        int n;

        ncmp = 0; nfail = 0; starve = 0;
        m_wa = '0; m_wd = '0; m_gid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = '0;
            tb_rf[i]    = '0;
        end
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;

        repeat (2) cycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, g0, g1);

        // Single execute write
        cycle(1'b0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, g0, g1);
        idle();

        // Both valid: load first, then the held execute request
        cycle(1'b0, 1'b1, 5'd3, 64'hAA, 1'b1, 5'd4, 64'hBB, g0, g1);
        cycle(1'b0, 1'b1, 5'd3, 64'hAA, 1'b0, 5'd0, 64'd0, g0, g1);
        idle();

        // Starvation guard under continuous load traffic
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 5'd9, 64'h900 + 64'(i), 1'b1, 5'd10, 64'hA00 + 64'(i), g0, g1);
            if (g0) break;
            n++;
        end
        chk("starve_wait", 64'(n), 64'(LIMIT));
        cycle(1'b0, 1'b1, 5'd11, 64'hB11, 1'b1, 5'd12, 64'hC12, g0, g1);
        chk("starve_cleared", 64'(g1), 64'd1);
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd12, 64'hC13, g0, g1);
        idle();

        // XZR write retires but does not write
        cycle(1'b0, 1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd0, 64'd0, g0, g1);
        idle();

        // Reset right after a handshake with both valid
        cycle(1'b0, 1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, g0, g1);
        cycle(1'b1, 1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, g0, g1);
        cycle(1'b0, 1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, g0, g1);
        chk("post_reset_load_first", 64'(g1), 64'd1);
        cycle(1'b0, 1'b1, 5'd1, 64'h11, 1'b0, 5'd0, 64'd0, g0, g1);
        idle();

        // Same-address collision: load value lands first, execute overwrites
        cycle(1'b0, 1'b1, 5'd7, 64'd1, 1'b1, 5'd7, 64'd2, g0, g1);
        cycle(1'b0, 1'b1, 5'd7, 64'd1, 1'b0, 5'd0, 64'd0, g0, g1);
        idle();

        // Randomized traffic with requesters holding until granted
        p0 = 1'b0; p1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1;
                a0 = 5'($urandom_range(0, 31));
                d0 = {$urandom, $urandom};
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1;
                a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
                d1 = {$urandom, $urandom};
            end
            r = ($urandom_range(0, 59) == 0);
            cycle(r, p0, a0, d0, p1, a1, d1, g0, g1);
            if (g0 || r) p0 = 1'b0;
            if (g1 || r) p1 = 1'b0;
        end

        repeat (3) idle();
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("rf_X%0d", i), tb_rf[i], model_rf[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end

endmodule
